// File: rtl/bw_pkg.sv
// Shared types and helpers for the Baugh-Wooley product accumulator.
// ext_product widens a multiplier product to accumulator width per its signedness.
package bw_pkg;

  localparam int BW_WIDTH     = 4;
  localparam int BW_ACC_WIDTH = 16;
  localparam int BW_MAX_W     = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // p carries a pw-bit product in its low bits; callers slice the result to their width.
  function automatic logic [BW_MAX_W-1:0] ext_product(
    input logic [BW_MAX_W-1:0] p,
    input int                  pw,
    input logic                signed_flag
  );
    logic [BW_MAX_W-1:0] hi_mask;
    logic [BW_MAX_W-1:0] msb_mask;
    logic                fill;
    hi_mask  = {BW_MAX_W{1'b1}} << pw;
    msb_mask = BW_MAX_W'(1) << (pw - 1);
    fill     = signed_flag & (|(p & msb_mask));
    return (p & ~hi_mask) | (fill ? hi_mask : '0);
  endfunction

endpackage

// File: rtl/bw_mac_accum.sv
// Accumulates bursts of multiplier products; result valid the cycle after the last beat.
// ready_o drops while a result is held and rises the cycle after it is consumed.
module bw_mac_accum
  import bw_pkg::*;
#(
  parameter int WIDTH       = BW_WIDTH,
  parameter int ACC_WIDTH   = BW_ACC_WIDTH,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic [2*WIDTH-1:0]     p_i,
  input  logic                   p_signed_i,
  input  logic                   last_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic [ACC_WIDTH-1:0]   sum_o,
  output logic [COUNT_WIDTH-1:0] count_o,
  output logic                   overflow_o,
  output logic                   valid_o,
  input  logic                   ready_i
);

  localparam int PW = 2 * WIDTH;

  if (ACC_WIDTH < 2 * WIDTH + 1 || ACC_WIDTH > BW_MAX_W) begin : g_bad_acc_width
    $error("bw_mac_accum: ACC_WIDTH must be in [2*WIDTH+1, BW_MAX_W]");
  end

  state_e                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;

  logic [ACC_WIDTH-1:0]   ext;
  logic [ACC_WIDTH-1:0]   sum;
  logic                   add_ovf;

  assign ext = ACC_WIDTH'(ext_product(BW_MAX_W'(p_i), PW, p_signed_i));
  assign sum = acc_q + ext;
  // Signed overflow: like-signed operands producing a result of the other sign.
  assign add_ovf = (acc_q[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) &&
                   (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);

  assign ready_o    = (state_q != HOLD);
  assign valid_o    = (state_q == HOLD);
  assign sum_o      = acc_q;
  assign count_o    = cnt_q;
  assign overflow_o = ovf_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clear_i) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, ACCUM: begin
          if (valid_i) begin
            acc_d   = sum;
            ovf_d   = ovf_q | add_ovf;
            cnt_d   = (&cnt_q) ? cnt_q : cnt_q + COUNT_WIDTH'(1);
            state_d = last_i ? HOLD : ACCUM;
          end
        end
        HOLD: begin
          if (ready_i) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_bw_mac_accum.sv
// Directed and swept checks of bw_mac_accum with WIDTH=4, ACC_WIDTH=16.
module tb_bw_mac_accum;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        clear_i;
  logic [7:0]  p_i;
  logic        p_signed_i;
  logic        last_i;
  logic        valid_i;
  logic        ready_o;
  logic [15:0] sum_o;
  logic [7:0]  count_o;
  logic        overflow_o;
  logic        valid_o;
  logic        ready_i;

  int errors = 0;
  int checks = 0;

  bw_mac_accum #(.WIDTH(4), .ACC_WIDTH(16), .COUNT_WIDTH(8)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (clear_i),
    .p_i        (p_i),
    .p_signed_i (p_signed_i),
    .last_i     (last_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .sum_o      (sum_o),
    .count_o    (count_o),
    .overflow_o (overflow_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Golden multiplier: operand values as integers, product truncated to 8 bits.
  function automatic int opval(input int v, input bit s);
    return (s && v >= 8) ? v - 16 : v;
  endfunction

  // Called just after a falling edge; returns just after the falling edge following acceptance.
  task automatic send_beat(input logic [7:0] p, input logic sgn, input logic last);
    int n;
    p_i = p; p_signed_i = sgn; last_i = last; valid_i = 1'b1;
    n = 0;
    while (!ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (!ready_o) chk("accept_timeout", 32'(ready_o), 32'd1);
    @(negedge clk_i);
    valid_i = 1'b0; last_i = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [15:0] s, input logic [7:0] c,
                               input logic o, input int stall);
    chk({tag, "_valid"}, 32'(valid_o), 32'd1);
    chk({tag, "_sum"},   32'(sum_o),   32'(s));
    chk({tag, "_count"}, 32'(count_o), 32'(c));
    chk({tag, "_ovf"},   32'(overflow_o), 32'(o));
    ready_i = 1'b0;
    repeat (stall) @(negedge clk_i);
    if (stall > 0) chk({tag, "_stall_sum"}, 32'(sum_o), 32'(s));
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
    chk({tag, "_done_valid"}, 32'(valid_o), 32'd0);
    chk({tag, "_done_ready"}, 32'(ready_o), 32'd1);
    chk({tag, "_done_sum"},   32'(sum_o),   32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; p_i = '0; p_signed_i = 1'b0;
    last_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // 1. reset state
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_sum",   32'(sum_o),   32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_ovf",   32'(overflow_o), 32'd0);

    // 2. unsigned 15*15 x3
    send_beat(8'hE1, 1'b0, 1'b0);
    chk("t2_run_sum", 32'(sum_o), 32'd225);
    chk("t2_run_valid", 32'(valid_o), 32'd0);
    send_beat(8'hE1, 1'b0, 1'b0);
    send_beat(8'hE1, 1'b0, 1'b1);
    expect_result("t2", 16'h02A3, 8'd3, 1'b0, 2);

    // 3. signed -64 + 64
    send_beat(8'hC0, 1'b1, 1'b0);
    chk("t3_run_sum", 32'(sum_o), 32'hFFC0);
    send_beat(8'h40, 1'b1, 1'b1);
    expect_result("t3", 16'h0000, 8'd2, 1'b0, 0);

    // 4. 0x88 unsigned (+136) then signed (-120)
    send_beat(8'h88, 1'b0, 1'b0);
    send_beat(8'h88, 1'b1, 1'b1);
    expect_result("t4", 16'h0010, 8'd2, 1'b0, 1);

    // 5. 146 x 225 = 32850 crosses +32767
    for (int i = 1; i <= 146; i++) send_beat(8'hE1, 1'b0, (i == 146));
    expect_result("t5", 16'h8052, 8'd146, 1'b1, 0);
    chk("t5_ovf_cleared", 32'(overflow_o), 32'd0);
    send_beat(8'h01, 1'b0, 1'b1);
    expect_result("t5_next", 16'h0001, 8'd1, 1'b0, 0);

    // 6a. HOLD ignores valid_i while ready_i=0
    send_beat(8'h05, 1'b0, 1'b1);
    p_i = 8'h11; p_signed_i = 1'b0; last_i = 1'b1; valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("t6_hold_ready", 32'(ready_o), 32'd0);
      chk("t6_hold_sum",   32'(sum_o),   32'd5);
      chk("t6_hold_count", 32'(count_o), 32'd1);
    end
    valid_i = 1'b0; last_i = 1'b0;
    expect_result("t6_hold", 16'h0005, 8'd1, 1'b0, 0);

    // 6b. clear mid-burst discards the coincident beat
    send_beat(8'h10, 1'b0, 1'b0);
    send_beat(8'h20, 1'b0, 1'b0);
    p_i = 8'h30; valid_i = 1'b1; clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0; valid_i = 1'b0;
    chk("t6_clr_sum",   32'(sum_o),   32'd0);
    chk("t6_clr_count", 32'(count_o), 32'd0);
    chk("t6_clr_valid", 32'(valid_o), 32'd0);
    send_beat(8'h07, 1'b0, 1'b1);
    expect_result("t6_after_clr", 16'h0007, 8'd1, 1'b0, 0);

    // 6c. clear drops a held result
    send_beat(8'h09, 1'b0, 1'b1);
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    chk("t6_clrhold_valid", 32'(valid_o), 32'd0);
    chk("t6_clrhold_sum",   32'(sum_o),   32'd0);

    // 6d. asynchronous reset mid-burst
    send_beat(8'h22, 1'b0, 1'b0);
    send_beat(8'hF0, 1'b1, 1'b0);
    chk("t6_pre_rst_count", 32'(count_o), 32'd2);
    #1 rst_ni = 1'b0;
    #1;
    chk("t6_rst_sum",   32'(sum_o),   32'd0);
    chk("t6_rst_count", 32'(count_o), 32'd0);
    chk("t6_rst_ready", 32'(ready_o), 32'd1);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("t6_rst_valid", 32'(valid_o), 32'd0);

    // Sweep: every sign mode and operand pair as a single-beat burst
    for (int m = 0; m < 4; m++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          int av, bv, pr;
          bit as, bs;
          as = m[1]; bs = m[0];
          av = opval(a, as); bv = opval(b, bs);
          pr = av * bv;
          send_beat(8'(pr), as | bs, 1'b1);
          expect_result($sformatf("sw_m%0d_a%0d_b%0d", m, a, b), 16'(pr), 8'd1, 1'b0,
                        int'($urandom_range(0, 3)));
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
